// File: rtl/spi_cmd_pkg.sv
// Shared defaults, header layout and FSM state encoding for the SPI command decoder.
package spi_cmd_pkg;

    localparam int BYTE_W_DEF     = 8;
    localparam int ADDR_W_DEF     = 7;
    localparam int DATA_BYTES_DEF = 4;
    localparam int INCR_BIT       = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to 1 so an idle (high) chip select produces no edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI frames {header, data bytes...} into register-write strobes with
// auto-increment addressing, frame error detection and good/bad frame counters.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int BYTE_W     = BYTE_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_BYTES = DATA_BYTES_DEF,
    parameter int DATA_W     = BYTE_W * DATA_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    input  logic              csn,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic [BYTE_W-1:0] tx_byte,
    output logic [15:0]       pkt_count,
    output logic [7:0]        err_count
);

    localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    logic csn_sync, csn_rise, csn_fall;

    sync_edge u_csn_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (csn),
        .sync_out (csn_sync),
        .rise     (csn_rise),
        .fall     (csn_fall)
    );

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              incr_q, incr_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [1:0]        live_q, live_d;
    logic              arm_q, arm_d;

    // The synchronizer's reset value of 1 fabricates a falling edge if csn is
    // already low when reset releases. Frame starts are only accepted once csn
    // has been seen high through fully refilled synchronizer stages.
    always_comb begin
        live_d = (live_q == 2'd2) ? live_q : live_q + 2'd1;
        arm_d  = arm_q | ((live_q == 2'd2) & csn_sync);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        incr_d      = incr_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        tx_byte_d   = tx_byte_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_IDLE: begin
                if (csn_fall && arm_q) begin
                    state_d    = ST_HEADER;
                    tx_byte_d  = '0;
                    byte_idx_d = '0;
                end
            end
            ST_HEADER: begin
                if (byte_valid) begin
                    addr_d     = byte_in[ADDR_W-1:0];
                    incr_d     = byte_in[INCR_BIT];
                    byte_idx_d = '0;
                    tx_byte_d  = tx_byte_q ^ byte_in;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    word_d    = (word_q << BYTE_W) | DATA_W'(byte_in);
                    tx_byte_d = tx_byte_q ^ byte_in;
                    if (byte_idx_q == LAST_IDX) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = word_d;
                        byte_idx_d = '0;
                        addr_d     = incr_q ? addr_q + 1'b1 : addr_q;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame end is judged on the post-byte state so a coincident last byte completes the word.
        if (csn_rise && state_q != ST_IDLE) begin
            if (state_d == ST_DATA && byte_idx_d != '0) begin
                frame_err_d = 1'b1;
                if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
            state_d    = ST_IDLE;
            byte_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            incr_q      <= 1'b0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            tx_byte_q   <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            live_q      <= '0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            incr_q      <= incr_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            tx_byte_q   <= tx_byte_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            live_q      <= live_d;
            arm_q       <= arm_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign tx_byte   = tx_byte_q;
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule
